// File: rtl/ram_copy_dma.sv
// Block-copy engine: streams a run of words from a registered-output source RAM
// into a destination RAM, with a pause input that yields the ports mid-copy.
module ram_copy_dma #(
  parameter int unsigned width   = 16,
  parameter int unsigned widthad = 10
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [widthad-1:0] src_base,
  input  logic [widthad-1:0] dst_base,
  input  logic [widthad:0]   count,
  input  logic               pause,
  output logic               busy,
  output logic               done,
  output logic [widthad-1:0] src_address,
  input  logic [width-1:0]   src_q,
  output logic               dst_wren,
  output logic [widthad-1:0] dst_address,
  output logic [width-1:0]   dst_data
);

  localparam int unsigned IW = widthad + 1;

  typedef enum logic [1:0] {IDLE, FETCH, COPY, DONE} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      rd_idx, rd_idx_nxt;
  logic [IW-1:0]      wr_idx, wr_idx_nxt;
  logic [IW-1:0]      count_r;
  logic [widthad-1:0] src_base_r, dst_base_r;
  logic               latch;
  logic               last_word;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rd_idx     <= '0;
      wr_idx     <= '0;
      count_r    <= '0;
      src_base_r <= '0;
      dst_base_r <= '0;
    end else begin
      state  <= state_nxt;
      rd_idx <= rd_idx_nxt;
      wr_idx <= wr_idx_nxt;
      if (latch) begin
        count_r    <= count;
        src_base_r <= src_base;
        dst_base_r <= dst_base;
      end
    end
  end

  // Indices are one bit wider than addresses so a full-RAM count terminates exactly
  assign last_word = (wr_idx == count_r - IW'(1));

  // Next-state and index update
  always_comb begin
    state_nxt  = state;
    rd_idx_nxt = rd_idx;
    wr_idx_nxt = wr_idx;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch      = 1'b1;
          rd_idx_nxt = '0;
          wr_idx_nxt = '0;
          state_nxt  = (count == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (!pause) begin
          rd_idx_nxt = rd_idx + IW'(1);
          state_nxt  = COPY;
        end
      end
      COPY: begin
        if (pause) begin
          // The word in flight is dropped; rewind so it is fetched again
          rd_idx_nxt = wr_idx;
          state_nxt  = FETCH;
        end else begin
          wr_idx_nxt = wr_idx + IW'(1);
          if (last_word) begin
            state_nxt = DONE;
          end else begin
            rd_idx_nxt = rd_idx + IW'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state and indices
  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    dst_wren    = (state == COPY) && !pause;
    src_address = src_base_r + rd_idx[widthad-1:0];
    dst_address = dst_base_r + wr_idx[widthad-1:0];
    dst_data    = src_q;
  end

endmodule
